// File: rtl/ctrl_time_capture_15_pkg.sv
// Shared constants, state encoding and slot-slice macros for the time/value capture table.
// Optional overflow tracking is enabled by defining CTRL_CAP_OVF_EN (see top and interface).
`ifndef EXTENDED_SINGLE
`define EXTENDED_SINGLE 64
`endif

// Slot k (1-based) of a flat bus of w-bit fields starts at this bit.
`define CAP_SLOT_LO(k, w) (((k) - 1) * (w))

package ctrl_time_capture_15_pkg;

  localparam int N_EVT  = 15;
  localparam int CNT_W  = 12;
  localparam int DATA_W = `EXTENDED_SINGLE;
  localparam int IDX_W  = 4;
  localparam int DROP_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } cap_state_t;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // The scheduler updates its output at counter == time-1, so a change seen at c replays at c+1.
  function automatic cnt_t slot_time(input cnt_t c);
    return cnt_t'(c + cnt_t'(1));
  endfunction

endpackage

// File: rtl/ctrl_time_capture_15_if.sv
// Control/table bundle of the capture block; ovf/drop_cnt exist only with CTRL_CAP_OVF_EN defined.
interface ctrl_time_capture_15_if;
  import ctrl_time_capture_15_pkg::*;

  logic                     start;
  logic                     stop;
  cnt_t                     counter;
  data_t                    x;
  logic [N_EVT*CNT_W-1:0]   time_bus;
  logic [N_EVT*DATA_W-1:0]  value_bus;
  idx_t                     evt_cnt;
  logic                     busy;
  logic                     full;
  logic                     done;
  idx_t                     rd_idx;
  cnt_t                     rd_time;
  data_t                    rd_value;
`ifdef CTRL_CAP_OVF_EN
  logic                     ovf;
  logic [DROP_W-1:0]        drop_cnt;

  modport slave (
    input  start, stop, counter, x, rd_idx,
    output time_bus, value_bus, evt_cnt, busy, full, done, rd_time, rd_value, ovf, drop_cnt
  );

  modport master (
    output start, stop, counter, x, rd_idx,
    input  time_bus, value_bus, evt_cnt, busy, full, done, rd_time, rd_value, ovf, drop_cnt
  );
`else
  modport slave (
    input  start, stop, counter, x, rd_idx,
    output time_bus, value_bus, evt_cnt, busy, full, done, rd_time, rd_value
  );

  modport master (
    output start, stop, counter, x, rd_idx,
    input  time_bus, value_bus, evt_cnt, busy, full, done, rd_time, rd_value
  );
`endif

endinterface

// File: rtl/ctrl_time_capture_15_cap_table.sv
// N_EVT x (time, value) register file: one write port, registered read port, flat bus view.
module ctrl_cap_table
  import ctrl_time_capture_15_pkg::*;
(
  input  logic                    clk,
  input  logic                    sta_n,
  input  logic                    i_clr,
  input  logic                    i_we,
  input  idx_t                    i_widx,
  input  cnt_t                    i_wtime,
  input  data_t                   i_wval,
  input  idx_t                    i_ridx,
  output cnt_t                    o_rtime,
  output data_t                   o_rval,
  output logic [N_EVT*CNT_W-1:0]  o_time_bus,
  output logic [N_EVT*DATA_W-1:0] o_value_bus
);

  cnt_t  r_time [N_EVT];
  data_t r_val  [N_EVT];
  cnt_t  r_rtime;
  data_t r_rval;

  always_ff @(posedge clk) begin
    if (!sta_n || i_clr) begin
      for (int k = 0; k < N_EVT; k++) begin
        r_time[k] <= '0;
        r_val[k]  <= '0;
      end
    end else if (i_we) begin
      for (int k = 0; k < N_EVT; k++) begin
        if (i_widx == idx_t'(k + 1)) begin
          r_time[k] <= i_wtime;
          r_val[k]  <= i_wval;
        end
      end
    end
  end

  // Reads sample the array before this edge's write lands, so same-slot access returns the old entry.
  always_ff @(posedge clk) begin
    if (!sta_n) begin
      r_rtime <= '0;
      r_rval  <= '0;
    end else begin
      r_rtime <= '0;
      r_rval  <= '0;
      for (int k = 0; k < N_EVT; k++) begin
        if (i_ridx == idx_t'(k + 1)) begin
          r_rtime <= r_time[k];
          r_rval  <= r_val[k];
        end
      end
    end
  end

  assign o_rtime = r_rtime;
  assign o_rval  = r_rval;

  for (genvar g = 1; g <= N_EVT; g++) begin : g_bus
    assign o_time_bus[`CAP_SLOT_LO(g, CNT_W) +: CNT_W]   = r_time[g-1];
    assign o_value_bus[`CAP_SLOT_LO(g, DATA_W) +: DATA_W] = r_val[g-1];
  end

endmodule

// File: rtl/ctrl_time_capture_15.sv
// Records (counter+1, x) change events of a piecewise-constant control word into a replayable table.
// CTRL_CAP_OVF_EN: capture survives a full table and counts dropped changes in ovf/drop_cnt.
module ctrl_time_capture_15
  import ctrl_time_capture_15_pkg::*;
(
  input  logic                  clk,
  input  logic                  sta_n,
  ctrl_time_capture_15_if.slave bus
);

  cap_state_t r_state, w_state_nxt;
  data_t      r_ref, w_ref_nxt;
  cnt_t       r_prev_cnt, w_prev_cnt_nxt;
  idx_t       r_evt_cnt, w_evt_cnt_nxt;
  logic       r_done, w_done_nxt;
  logic       w_clr, w_we;
  logic       w_change, w_wrap, w_room;
  idx_t       w_widx;
  cnt_t       w_wtime;
`ifdef CTRL_CAP_OVF_EN
  logic              r_ovf, w_ovf_nxt;
  logic [DROP_W-1:0] r_drop, w_drop_nxt;
`endif

  assign w_change = (bus.x != r_ref);
  assign w_wrap   = (bus.counter < r_prev_cnt);
  assign w_room   = (r_evt_cnt < idx_t'(N_EVT));
  assign w_widx   = idx_t'(r_evt_cnt + 1'b1);
  assign w_wtime  = slot_time(bus.counter);

  always_ff @(posedge clk) begin
    if (!sta_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ref_nxt      = r_ref;
    w_prev_cnt_nxt = r_prev_cnt;
    w_evt_cnt_nxt  = r_evt_cnt;
    w_done_nxt     = 1'b0;
    w_clr          = 1'b0;
    w_we           = 1'b0;
`ifdef CTRL_CAP_OVF_EN
    w_ovf_nxt      = r_ovf;
    w_drop_nxt     = r_drop;
`endif
    if (bus.start) begin
      // Restart wins over stop and never signals done for the abandoned capture.
      w_state_nxt    = ST_ARMED;
      w_ref_nxt      = '0;
      w_prev_cnt_nxt = bus.counter;
      w_evt_cnt_nxt  = '0;
      w_clr          = 1'b1;
`ifdef CTRL_CAP_OVF_EN
      w_ovf_nxt      = 1'b0;
      w_drop_nxt     = '0;
`endif
    end else if (r_state == ST_ARMED) begin
      w_prev_cnt_nxt = bus.counter;
      if (w_wrap) begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        if (w_change) begin
          w_ref_nxt = bus.x;
          if (w_room) begin
            w_we          = 1'b1;
            w_evt_cnt_nxt = w_widx;
`ifndef CTRL_CAP_OVF_EN
            if (r_evt_cnt == idx_t'(N_EVT - 1)) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
`endif
          end
`ifdef CTRL_CAP_OVF_EN
          else begin
            w_ovf_nxt = 1'b1;
            if (r_drop != '1) begin
              w_drop_nxt = r_drop + 1'b1;
            end
          end
`endif
        end
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sta_n) begin
      r_ref      <= '0;
      r_prev_cnt <= '0;
      r_evt_cnt  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_ref      <= w_ref_nxt;
      r_prev_cnt <= w_prev_cnt_nxt;
      r_evt_cnt  <= w_evt_cnt_nxt;
      r_done     <= w_done_nxt;
    end
  end

`ifdef CTRL_CAP_OVF_EN
  always_ff @(posedge clk) begin
    if (!sta_n) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else begin
      r_ovf  <= w_ovf_nxt;
      r_drop <= w_drop_nxt;
    end
  end

  assign bus.ovf      = r_ovf;
  assign bus.drop_cnt = r_drop;
`endif

  ctrl_cap_table u_table (
    .clk         (clk),
    .sta_n       (sta_n),
    .i_clr       (w_clr),
    .i_we        (w_we),
    .i_widx      (w_widx),
    .i_wtime     (w_wtime),
    .i_wval      (bus.x),
    .i_ridx      (bus.rd_idx),
    .o_rtime     (bus.rd_time),
    .o_rval      (bus.rd_value),
    .o_time_bus  (bus.time_bus),
    .o_value_bus (bus.value_bus)
  );

  assign bus.evt_cnt = r_evt_cnt;
  assign bus.busy    = (r_state == ST_ARMED);
  assign bus.full    = (r_evt_cnt == idx_t'(N_EVT));
  assign bus.done    = r_done;

endmodule

// File: tb/tb_ctrl_time_capture_15.sv
// Directed bench for ctrl_time_capture_15; covers the default build and CTRL_CAP_OVF_EN.
module tb_ctrl_time_capture_15;
  import ctrl_time_capture_15_pkg::*;

  logic clk;
  logic sta_n;
  int   checks;
  int   failures;

  ctrl_time_capture_15_if bus ();

  ctrl_time_capture_15 dut (
    .clk   (clk),
    .sta_n (sta_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // One clock edge; inputs set before the call are sampled, counter then advances.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.counter = bus.counter + 12'd1;
  endtask

  function automatic cnt_t slot_t(input int k);
    return bus.time_bus[(k-1)*CNT_W +: CNT_W];
  endfunction

  function automatic data_t slot_v(input int k);
    return bus.value_bus[(k-1)*DATA_W +: DATA_W];
  endfunction

  task automatic test_reset();
    sta_n = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.x = '0; bus.rd_idx = '0; bus.counter = '0;
    tick(); tick();
    checks++; if (bus.evt_cnt !== 4'd0) begin failures++; $display("FAIL reset_evt_cnt got=%0d exp=0", bus.evt_cnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.rd_time !== '0 || bus.rd_value !== '0) begin failures++; $display("FAIL reset_rd got=%0d/%0d exp=0/0", bus.rd_time, bus.rd_value); end
    checks++; if (bus.time_bus !== '0 || bus.value_bus !== '0) begin failures++; $display("FAIL reset_table got nonzero exp=0"); end
    sta_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_hold();
    bus.counter = '0; bus.x = '0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    checks++; if (bus.evt_cnt !== 4'd0) begin failures++; $display("FAIL hold_evt_cnt got=%0d exp=0", bus.evt_cnt); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL hold_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.time_bus !== '0) begin failures++; $display("FAIL hold_no_write got=%h exp=0", bus.time_bus); end
  endtask

  task automatic test_two_changes();
    bus.counter = '0; bus.x = '0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (bus.counter != 12'd9) tick();
    bus.x = 64'd5; bus.rd_idx = 4'd1;
    tick();
    checks++; if (bus.rd_time !== 12'd0 || bus.rd_value !== 64'd0) begin failures++; $display("FAIL rw_same_slot got=%0d/%0d exp=0/0", bus.rd_time, bus.rd_value); end
    tick();
    checks++; if (bus.rd_time !== 12'd10 || bus.rd_value !== 64'd5) begin failures++; $display("FAIL rd_slot1 got=%0d/%0d exp=10/5", bus.rd_time, bus.rd_value); end
    while (bus.counter != 12'd20) tick();
    bus.x = 64'd7;
    tick(); tick();
    checks++; if (bus.evt_cnt !== 4'd2) begin failures++; $display("FAIL two_evt_cnt got=%0d exp=2", bus.evt_cnt); end
    checks++; if (slot_t(1) !== 12'd10 || slot_v(1) !== 64'd5) begin failures++; $display("FAIL two_slot1 got=%0d/%0d exp=10/5", slot_t(1), slot_v(1)); end
    checks++; if (slot_t(2) !== 12'd21 || slot_v(2) !== 64'd7) begin failures++; $display("FAIL two_slot2 got=%0d/%0d exp=21/7", slot_t(2), slot_v(2)); end
    checks++; if (slot_t(3) !== 12'd0 || slot_v(3) !== 64'd0) begin failures++; $display("FAIL two_slot3 got=%0d/%0d exp=0/0", slot_t(3), slot_v(3)); end
    bus.rd_idx = 4'd2;
    tick();
    checks++; if (bus.rd_time !== 12'd21 || bus.rd_value !== 64'd7) begin failures++; $display("FAIL rd_slot2 got=%0d/%0d exp=21/7", bus.rd_time, bus.rd_value); end
    bus.rd_idx = 4'd0;
    tick();
    checks++; if (bus.rd_time !== 12'd0 || bus.rd_value !== 64'd0) begin failures++; $display("FAIL rd_idx0 got=%0d/%0d exp=0/0", bus.rd_time, bus.rd_value); end
  endtask

  task automatic test_full();
    bus.counter = '0; bus.x = '0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      bus.x = 64'(i);
      tick();
    end
    checks++; if (bus.evt_cnt !== 4'd15) begin failures++; $display("FAIL full_evt_cnt got=%0d exp=15", bus.evt_cnt); end
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", bus.full); end
    checks++; if (slot_t(1) !== 12'd2 || slot_v(1) !== 64'd1) begin failures++; $display("FAIL full_slot1 got=%0d/%0d exp=2/1", slot_t(1), slot_v(1)); end
    checks++; if (slot_t(15) !== 12'd16 || slot_v(15) !== 64'd15) begin failures++; $display("FAIL full_slot15 got=%0d/%0d exp=16/15", slot_t(15), slot_v(15)); end
`ifdef CTRL_CAP_OVF_EN
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL ovf_still_armed got busy=%b done=%b exp=1/0", bus.busy, bus.done); end
    bus.x = 64'd16;
    tick();
    checks++; if (bus.ovf !== 1'b1 || bus.drop_cnt !== 8'd1) begin failures++; $display("FAIL ovf_drop got=%b/%0d exp=1/1", bus.ovf, bus.drop_cnt); end
    checks++; if (bus.busy !== 1'b1 || bus.evt_cnt !== 4'd15) begin failures++; $display("FAIL ovf_busy got=%b/%0d exp=1/15", bus.busy, bus.evt_cnt); end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin failures++; $display("FAIL ovf_stop got busy=%b done=%b exp=0/1", bus.busy, bus.done); end
`else
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin failures++; $display("FAIL full_end got busy=%b done=%b exp=0/1", bus.busy, bus.done); end
    bus.x = 64'd16;
    tick();
    checks++; if (bus.done !== 1'b0 || bus.evt_cnt !== 4'd15) begin failures++; $display("FAIL full_16th got done=%b cnt=%0d exp=0/15", bus.done, bus.evt_cnt); end
    checks++; if (slot_t(15) !== 12'd16 || slot_v(15) !== 64'd15) begin failures++; $display("FAIL full_slot15_kept got=%0d/%0d exp=16/15", slot_t(15), slot_v(15)); end
`endif
  endtask

  task automatic test_wrap();
    bus.counter = 12'd4090; bus.x = '0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.x = 64'(i);
      tick();
    end
    tick(); tick();
    bus.x = 64'd9;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin failures++; $display("FAIL wrap_end got busy=%b done=%b exp=0/1", bus.busy, bus.done); end
    checks++; if (bus.evt_cnt !== 4'd3) begin failures++; $display("FAIL wrap_evt_cnt got=%0d exp=3", bus.evt_cnt); end
    checks++; if (slot_t(3) !== 12'd4094 || slot_v(3) !== 64'd3) begin failures++; $display("FAIL wrap_slot3 got=%0d/%0d exp=4094/3", slot_t(3), slot_v(3)); end
    checks++; if (slot_t(4) !== 12'd0 || slot_v(4) !== 64'd0) begin failures++; $display("FAIL wrap_no_write got=%0d/%0d exp=0/0", slot_t(4), slot_v(4)); end
    tick();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL wrap_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_start_stop();
    bus.counter = 12'd100; bus.x = '0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.x = 64'd4;
    tick();
    checks++; if (bus.evt_cnt !== 4'd1) begin failures++; $display("FAIL ss_pre_evt got=%0d exp=1", bus.evt_cnt); end
    bus.x = '0; bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL ss_restart got busy=%b done=%b exp=1/0", bus.busy, bus.done); end
    checks++; if (bus.evt_cnt !== 4'd0 || bus.time_bus !== '0) begin failures++; $display("FAIL ss_cleared got cnt=%0d exp=0", bus.evt_cnt); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL ss_after got busy=%b done=%b exp=1/0", bus.busy, bus.done); end
    bus.counter = 12'd4090; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (bus.counter != 12'd4094) tick();
    bus.x = 64'd5; bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin failures++; $display("FAIL stop_chg_end got busy=%b done=%b exp=0/1", bus.busy, bus.done); end
    checks++; if (bus.evt_cnt !== 4'd1 || slot_t(1) !== 12'd4095 || slot_v(1) !== 64'd5) begin failures++; $display("FAIL stop_chg_slot got cnt=%0d t=%0d v=%0d exp=1/4095/5", bus.evt_cnt, slot_t(1), slot_v(1)); end
  endtask

  task automatic test_reset_mid();
    bus.counter = 12'd10; bus.x = '0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.x = 64'd3;
    tick();
    bus.rd_idx = 4'd1;
    tick();
    checks++; if (bus.rd_time !== 12'd12 || bus.rd_value !== 64'd3) begin failures++; $display("FAIL mid_pre_rd got=%0d/%0d exp=12/3", bus.rd_time, bus.rd_value); end
    sta_n = 1'b0; bus.x = 64'd8;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.evt_cnt !== 4'd0 || bus.full !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL mid_reset_ctl got busy=%b cnt=%0d full=%b done=%b exp=0", bus.busy, bus.evt_cnt, bus.full, bus.done); end
    checks++; if (bus.rd_time !== '0 || bus.rd_value !== '0) begin failures++; $display("FAIL mid_reset_rd got=%0d/%0d exp=0/0", bus.rd_time, bus.rd_value); end
    checks++; if (bus.time_bus !== '0 || bus.value_bus !== '0) begin failures++; $display("FAIL mid_reset_table got nonzero exp=0"); end
    sta_n = 1'b1;
    tick();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL mid_after got busy=%b done=%b exp=0/0", bus.busy, bus.done); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_idle_hold();
    test_two_changes();
    test_full();
    test_wrap();
    test_start_stop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
